// File: rtl/instr_dispatch_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instr_dispatch_fsm                                         |
// | Description : Fetch/decode/dispatch sequencer driving the start/done/    |
// |               donefetch handshake of the op FSMs. Optional watchdog on   |
// |               EXEC is enabled with macro DISPATCH_WDOG_EN.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module instr_dispatch_fsm #(
   parameter int AW        = 8,
   parameter int NUM_UNITS = 8,
   parameter int RESET_PC  = 0,
   parameter int WDOG_MAX  = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   output logic [AW-1:0]        mem_addr,
   output logic                 mem_rd,
   input  logic                 mem_ack,
   input  logic [15:0]          mem_data,
   output logic [NUM_UNITS-1:0] start_vec,
   input  logic [NUM_UNITS-1:0] done_vec,
   output logic                 donefetch,
   output logic [5:0]           parameter1,
   output logic [5:0]           parameter2,
   output logic [AW-1:0]        pc,
   output logic                 halted,
   output logic                 illegal,
   output logic                 timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_RETIRE = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] c_op_nop  = 4'h0;
   localparam logic [3:0] c_op_halt = 4'hF;

   state_t               r_state;
   state_t               w_next;
   logic [15:0]          r_ir;
   logic [AW-1:0]        r_pc;
   logic                 r_illegal;
   logic [3:0]           w_opcode;
   logic [NUM_UNITS-1:0] w_start;
   logic                 w_done;
   logic                 w_illegal_op;
   logic                 w_wdog_hit;

   assign w_opcode     = r_ir[15:12];
   assign w_illegal_op = (w_opcode != c_op_halt) && ({28'd0, w_opcode} >= 32'(NUM_UNITS));

   // One-hot start decoded from the IR; only the selected unit's done is honoured
   generate
      for (genvar k = 0; k < NUM_UNITS; k++) begin : g_start
         assign w_start[k] = (r_state == S_EXEC) && ({28'd0, w_opcode} == 32'(k));
      end
   endgenerate

   assign w_done = |(done_vec & w_start);

`ifdef DISPATCH_WDOG_EN
   localparam int c_wdog_w = $clog2(WDOG_MAX + 1);

   logic [c_wdog_w-1:0] r_wdog;
   logic                r_timeout;

   assign w_wdog_hit  = (r_wdog == c_wdog_w'(WDOG_MAX - 1));
   assign timeout_err = r_timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else if (r_state == S_DECODE) begin
         r_wdog <= '0;
      end else if (r_state == S_EXEC) begin
         r_wdog <= r_wdog + 1'b1;
         if (w_wdog_hit && !w_done)
            r_timeout <= 1'b1;
      end
   end
`else
   assign w_wdog_hit  = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (run) w_next = S_FETCH;
         S_FETCH:  if (mem_ack) w_next = S_DECODE;
         S_DECODE: begin
            if (w_opcode == c_op_halt)
               w_next = S_HALT;
            else if ((w_opcode == c_op_nop) || w_illegal_op)
               w_next = S_RETIRE;
            else
               w_next = S_EXEC;
         end
         S_EXEC:   if (w_done || w_wdog_hit) w_next = S_RETIRE;
         S_RETIRE: w_next = run ? S_FETCH : S_IDLE;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_IDLE;
      endcase
   end

   // IR doubles as the parameter holding register: it only loads on the fetch ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= AW'(RESET_PC);
         r_ir      <= '0;
         r_illegal <= 1'b0;
      end else begin
         if ((r_state == S_FETCH) && mem_ack)
            r_ir <= mem_data;
         if ((r_state == S_DECODE) && w_illegal_op)
            r_illegal <= 1'b1;
         if (r_state == S_RETIRE)
            r_pc <= r_pc + 1'b1;
      end
   end

   assign mem_addr   = r_pc;
   assign mem_rd     = (r_state == S_FETCH);
   assign start_vec  = w_start;
   assign donefetch  = (r_state == S_RETIRE);
   assign parameter1 = r_ir[11:6];
   assign parameter2 = r_ir[5:0];
   assign pc         = r_pc;
   assign halted     = (r_state == S_HALT);
   assign illegal    = r_illegal;

endmodule
`default_nettype wire
